// File: rtl/ibex_pkg.sv
// Shared LSU types and helpers.
//   ls_type_e   : access size of a load/store
//   ls_be_mask  : byte-enable mask for an access size, LSB-aligned
package ibex_pkg;

   localparam int unsigned AddrW = 32;
   localparam int unsigned DataW = 32;
   localparam int unsigned BeW   = DataW / 8;

   typedef enum logic [1:0] {
      LS_WORD = 2'b00,
      LS_HALF = 2'b01,
      LS_BYTE = 2'b10
   } ls_type_e;

   // Byte lanes touched by an access of the given size at offset 0.
   function automatic logic [BeW-1:0] ls_be_mask(input ls_type_e t);
      case (t)
         LS_HALF: ls_be_mask = 4'b0011;
         LS_BYTE: ls_be_mask = 4'b0001;
         default: ls_be_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Combinational read-data alignment: shifts the {hi,lo} word pair right by the
// byte offset and zero/sign-extends the selected byte, half or word.
//   hi_word / lo_word : response words (hi is zero for an unsplit access)
//   offset            : byte offset of the access
//   ls_type           : access size
//   sign_ext          : sign-extend byte/half results
//   rdata             : aligned, extended result
module ibex_lsu_rdata_align
   import ibex_pkg::*;
(
   input  logic [DataW-1:0] hi_word,
   input  logic [DataW-1:0] lo_word,
   input  logic [1:0]       offset,
   input  ls_type_e         ls_type,
   input  logic             sign_ext,
   output logic [DataW-1:0] rdata
);

   logic [2*DataW-1:0] pair_shifted;
   logic [DataW-1:0]   raw;

   assign pair_shifted = {hi_word, lo_word} >> {offset, 3'b000};
   assign raw          = pair_shifted[DataW-1:0];

   // Size/sign extension of the shifted word.
   always_comb begin
      rdata = raw;
      case (ls_type)
         LS_BYTE: rdata = {{24{sign_ext & raw[7]}}, raw[7:0]};
         LS_HALF: rdata = {{16{sign_ext & raw[15]}}, raw[15:0]};
         default: rdata = raw;
      endcase
   end

endmodule

// File: rtl/ibex_load_store_ctrl.sv
// Load/store unit: accepts one request from ID/EX, drives the data-memory
// req/gnt/rvalid bus, splits misaligned accesses into two word transactions
// and returns aligned/extended load data with a one-cycle completion pulse.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   lsu_*_i               : request from ID/EX (accepted on lsu_req_i & lsu_ready_o)
//   lsu_ready_o/busy_o    : idle / transaction in flight
//   data_*                : data-memory bus (one outstanding transaction)
//   lsu_rdata_o/_we_o     : load result and RF write strobe
//   lsu_resp_valid_o      : completion pulse, lsu_err_o/lsu_err_addr_o qualify it
module ibex_load_store_ctrl
   import ibex_pkg::*;
#(
   parameter bit MisalignedEn = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             lsu_req_i,
   input  logic             lsu_we_i,
   input  ls_type_e         lsu_type_i,
   input  logic             lsu_sign_ext_i,
   input  logic [AddrW-1:0] lsu_addr_i,
   input  logic [DataW-1:0] lsu_wdata_i,
   output logic             lsu_ready_o,
   output logic             lsu_busy_o,
   output logic             data_req_o,
   input  logic             data_gnt_i,
   output logic [AddrW-1:0] data_addr_o,
   output logic             data_we_o,
   output logic [BeW-1:0]   data_be_o,
   output logic [DataW-1:0] data_wdata_o,
   input  logic             data_rvalid_i,
   input  logic [DataW-1:0] data_rdata_i,
   input  logic             data_err_i,
   output logic [DataW-1:0] lsu_rdata_o,
   output logic             lsu_rdata_we_o,
   output logic             lsu_resp_valid_o,
   output logic             lsu_err_o,
   output logic [AddrW-1:0] lsu_err_addr_o
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_GNT0 = 3'd1;
   localparam logic [2:0] WAIT_RV0  = 3'd2;
   localparam logic [2:0] WAIT_GNT1 = 3'd3;
   localparam logic [2:0] WAIT_RV1  = 3'd4;
   localparam logic [2:0] MIS_ERR   = 3'd5;

   logic [2:0]       state_q, state_d;
   logic             req_q, req_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic             we_q, we_d;
   logic [BeW-1:0]   be_q, be_d;
   logic [DataW-1:0] wdata_q, wdata_d;
   logic [BeW-1:0]   be_hi_q, be_hi_d;
   logic [DataW-1:0] wdata_hi_q, wdata_hi_d;
   logic [AddrW-1:0] lsu_addr_q, lsu_addr_d;
   ls_type_e         type_q, type_d;
   logic             sign_q, sign_d;
   logic             split_q, split_d;
   logic [DataW-1:0] rdata_q, rdata_d;

   logic             resp_valid, resp_err, resp_we;
   logic [AddrW-1:0] resp_err_addr;

   // Request decode: lane mask placed at the byte offset across two words.
   logic [1:0]         req_offset;
   logic [2*BeW-1:0]   req_be8;
   logic [2*DataW-1:0] req_wdata64;
   logic               req_misaligned;

   assign req_offset     = lsu_addr_i[1:0];
   assign req_be8        = {4'b0000, ls_be_mask(lsu_type_i)} << req_offset;
   assign req_wdata64    = {32'b0, lsu_wdata_i} << {req_offset, 3'b000};
   assign req_misaligned = |req_be8[2*BeW-1:BeW];

   // Read-data path: pair the saved low word with the second response when split.
   logic             in_rv1;
   logic [DataW-1:0] align_hi, align_lo, align_rdata;

   assign in_rv1   = (state_q == WAIT_RV1);
   assign align_lo = in_rv1 ? rdata_q : data_rdata_i;
   assign align_hi = in_rv1 ? data_rdata_i : 32'b0;

   ibex_lsu_rdata_align u_align (
      .hi_word  (align_hi),
      .lo_word  (align_lo),
      .offset   (lsu_addr_q[1:0]),
      .ls_type  (type_q),
      .sign_ext (sign_q),
      .rdata    (align_rdata)
   );

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         be_hi_q    <= '0;
         wdata_hi_q <= '0;
         lsu_addr_q <= '0;
         type_q     <= LS_WORD;
         sign_q     <= 1'b0;
         split_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         be_hi_q    <= be_hi_d;
         wdata_hi_q <= wdata_hi_d;
         lsu_addr_q <= lsu_addr_d;
         type_q     <= type_d;
         sign_q     <= sign_d;
         split_q    <= split_d;
         rdata_q    <= rdata_d;
      end
   end

   // Next-state, next-datapath and completion decode.
   always_comb begin
      state_d       = state_q;
      req_d         = req_q;
      addr_d        = addr_q;
      we_d          = we_q;
      be_d          = be_q;
      wdata_d       = wdata_q;
      be_hi_d       = be_hi_q;
      wdata_hi_d    = wdata_hi_q;
      lsu_addr_d    = lsu_addr_q;
      type_d        = type_q;
      sign_d        = sign_q;
      split_d       = split_q;
      rdata_d       = rdata_q;
      resp_valid    = 1'b0;
      resp_err      = 1'b0;
      resp_we       = 1'b0;
      resp_err_addr = '0;

      case (state_q)
         IDLE: begin
            if (lsu_req_i) begin
               lsu_addr_d = lsu_addr_i;
               we_d       = lsu_we_i;
               type_d     = lsu_type_i;
               sign_d     = lsu_sign_ext_i;
               if (req_misaligned && !MisalignedEn) begin
                  state_d = MIS_ERR;
               end else begin
                  state_d    = WAIT_GNT0;
                  req_d      = 1'b1;
                  addr_d     = {lsu_addr_i[31:2], 2'b00};
                  be_d       = req_be8[BeW-1:0];
                  wdata_d    = req_wdata64[DataW-1:0];
                  be_hi_d    = req_be8[2*BeW-1:BeW];
                  wdata_hi_d = req_wdata64[2*DataW-1:DataW];
                  split_d    = req_misaligned;
               end
            end
         end
         WAIT_GNT0: begin
            if (data_gnt_i) begin
               req_d   = 1'b0;
               state_d = WAIT_RV0;
            end
         end
         WAIT_RV0: begin
            if (data_rvalid_i) begin
               if (data_err_i) begin
                  // First part faulted: second part is never issued.
                  resp_valid    = 1'b1;
                  resp_err      = 1'b1;
                  resp_err_addr = lsu_addr_q;
                  state_d       = IDLE;
               end else if (split_q) begin
                  rdata_d = data_rdata_i;
                  req_d   = 1'b1;
                  addr_d  = {lsu_addr_q[31:2] + 30'd1, 2'b00};
                  be_d    = be_hi_q;
                  wdata_d = wdata_hi_q;
                  state_d = WAIT_GNT1;
               end else begin
                  resp_valid = 1'b1;
                  resp_we    = ~we_q;
                  state_d    = IDLE;
               end
            end
         end
         WAIT_GNT1: begin
            if (data_gnt_i) begin
               req_d   = 1'b0;
               state_d = WAIT_RV1;
            end
         end
         WAIT_RV1: begin
            if (data_rvalid_i) begin
               resp_valid = 1'b1;
               if (data_err_i) begin
                  resp_err      = 1'b1;
                  resp_err_addr = addr_q;
               end else begin
                  resp_we = ~we_q;
               end
               state_d = IDLE;
            end
         end
         MIS_ERR: begin
            resp_valid    = 1'b1;
            resp_err      = 1'b1;
            resp_err_addr = lsu_addr_q;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign lsu_ready_o      = (state_q == IDLE);
   assign lsu_busy_o       = (state_q != IDLE);
   assign data_req_o       = req_q;
   assign data_addr_o      = addr_q;
   assign data_we_o        = we_q;
   assign data_be_o        = be_q;
   assign data_wdata_o     = wdata_q;
   assign lsu_resp_valid_o = resp_valid;
   assign lsu_err_o        = resp_err;
   assign lsu_err_addr_o   = resp_err_addr;
   assign lsu_rdata_we_o   = resp_we;
   assign lsu_rdata_o      = resp_we ? align_rdata : 32'b0;

endmodule

// File: tb/tb_ibex_load_store_ctrl.sv
// Directed bench for ibex_load_store_ctrl: table of single transactions with
// hand-computed bus and response values, plus sequences for reset, held
// requests, stray bus responses and the MisalignedEn=0 variant.
module tb_ibex_load_store_ctrl;
   import ibex_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lsu_req = 1'b0, lsu_we = 1'b0, lsu_sign = 1'b0;
   ls_type_e    lsu_type = LS_WORD;
   logic [31:0] lsu_addr = '0, lsu_wdata = '0;
   logic        data_gnt = 1'b0, data_rvalid = 1'b0, data_err = 1'b0;
   logic [31:0] data_rdata = '0;

   logic        lsu_ready, lsu_busy, data_req, data_we, rdata_we, resp, err;
   logic [31:0] data_addr, data_wdata, rdata, err_addr;
   logic [3:0]  data_be;

   logic        nm_ready, nm_busy, nm_req, nm_we, nm_rdata_we, nm_resp, nm_err;
   logic [31:0] nm_addr, nm_wdata, nm_rdata, nm_err_addr;
   logic [3:0]  nm_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ibex_load_store_ctrl dut (
      .clk_i(clk), .rst_i(rst),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
      .lsu_sign_ext_i(lsu_sign), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
      .lsu_ready_o(lsu_ready), .lsu_busy_o(lsu_busy),
      .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
      .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
      .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err),
      .lsu_rdata_o(rdata), .lsu_rdata_we_o(rdata_we), .lsu_resp_valid_o(resp),
      .lsu_err_o(err), .lsu_err_addr_o(err_addr)
   );

   ibex_load_store_ctrl #(.MisalignedEn(1'b0)) dut_nm (
      .clk_i(clk), .rst_i(rst),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
      .lsu_sign_ext_i(lsu_sign), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
      .lsu_ready_o(nm_ready), .lsu_busy_o(nm_busy),
      .data_req_o(nm_req), .data_gnt_i(data_gnt), .data_addr_o(nm_addr),
      .data_we_o(nm_we), .data_be_o(nm_be), .data_wdata_o(nm_wdata),
      .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err),
      .lsu_rdata_o(nm_rdata), .lsu_rdata_we_o(nm_rdata_we), .lsu_resp_valid_o(nm_resp),
      .lsu_err_o(nm_err), .lsu_err_addr_o(nm_err_addr)
   );

   typedef struct {
      logic        we;
      ls_type_e    typ;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic        e0;
      logic        e1;
      logic        split;
      logic [31:0] a0;
      logic [3:0]  be0;
      logic [31:0] wd0;
      logic [31:0] a1;
      logic [3:0]  be1;
      logic [31:0] wd1;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_eaddr;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic we, input ls_type_e t, input logic s,
                        input logic [31:0] a, input logic [31:0] wd);
      lsu_req = 1'b1; lsu_we = we; lsu_type = t; lsu_sign = s;
      lsu_addr = a; lsu_wdata = wd;
   endtask

   // One transaction: grant in the cycle the request appears, rvalid next cycle.
   task automatic run_vec(input int i, input vec_t v);
      @(negedge clk);
      chk($sformatf("v%0d ready", i), 32'(lsu_ready), 32'd1);
      issue(v.we, v.typ, v.sgn, v.addr, v.wdata);
      @(negedge clk);
      lsu_req = 1'b0;
      chk($sformatf("v%0d req0", i), 32'(data_req), 32'd1);
      chk($sformatf("v%0d addr0", i), data_addr, v.a0);
      chk($sformatf("v%0d be0", i), 32'(data_be), 32'(v.be0));
      chk($sformatf("v%0d we0", i), 32'(data_we), 32'(v.we));
      if (v.we) chk($sformatf("v%0d wdata0", i), data_wdata, v.wd0);
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0;
      chk($sformatf("v%0d req0_drop", i), 32'(data_req), 32'd0);
      data_rvalid = 1'b1; data_rdata = v.rd0; data_err = v.e0;
      #1;
      if (v.split && !v.e0) begin
         chk($sformatf("v%0d resp_mid", i), 32'(resp), 32'd0);
         @(negedge clk);
         data_rvalid = 1'b0; data_err = 1'b0; data_rdata = '0;
         chk($sformatf("v%0d req1", i), 32'(data_req), 32'd1);
         chk($sformatf("v%0d addr1", i), data_addr, v.a1);
         chk($sformatf("v%0d be1", i), 32'(data_be), 32'(v.be1));
         if (v.we) chk($sformatf("v%0d wdata1", i), data_wdata, v.wd1);
         data_gnt = 1'b1;
         @(negedge clk);
         data_gnt = 1'b0;
         data_rvalid = 1'b1; data_rdata = v.rd1; data_err = v.e1;
         #1;
      end
      chk($sformatf("v%0d resp", i), 32'(resp), 32'd1);
      chk($sformatf("v%0d err", i), 32'(err), 32'(v.exp_err));
      if (v.exp_err) chk($sformatf("v%0d err_addr", i), err_addr, v.exp_eaddr);
      chk($sformatf("v%0d rdata_we", i), 32'(rdata_we), 32'(!v.we && !v.exp_err));
      if (!v.we && !v.exp_err) chk($sformatf("v%0d rdata", i), rdata, v.exp_rdata);
      @(negedge clk);
      data_rvalid = 1'b0; data_err = 1'b0; data_rdata = '0;
      #1;
      chk($sformatf("v%0d resp_once", i), 32'(resp), 32'd0);
      chk($sformatf("v%0d req_idle", i), 32'(data_req), 32'd0);
      chk($sformatf("v%0d ready_after", i), 32'(lsu_ready), 32'd1);
   endtask

   initial begin
      //          we    typ      sgn  addr          wdata         rd0           rd1           e0    e1    split a0            be0      wd0           a1            be1      wd1           exp_rdata     err   eaddr
      vecs[0]  = '{1'b0, LS_WORD, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, LS_BYTE, 1'b1, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, LS_BYTE, 1'b0, 32'h0000_0103, 32'h0,        32'h8012_3456, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_0080, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, LS_WORD, 1'b0, 32'h0000_0202, 32'h1122_3344, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0200, 4'b1100, 32'h3344_0000, 32'h0000_0204, 4'b0011, 32'h0000_1122, 32'h0,        1'b0, 32'h0};
      vecs[4]  = '{1'b0, LS_WORD, 1'b0, 32'h0000_0203, 32'h0,        32'h44AA_BBCC, 32'hDD11_2233, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 4'b1000, 32'h0,        32'h0000_0204, 4'b0111, 32'h0,        32'h1122_3344, 1'b0, 32'h0};
      vecs[5]  = '{1'b0, LS_HALF, 1'b1, 32'hFFFF_FFFF, 32'h0,        32'h1234_5678, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'h0,        32'h0,        4'b0001, 32'h0,        32'h0,        1'b1, 32'hFFFF_FFFF};
      vecs[6]  = '{1'b0, LS_HALF, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_1234, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, LS_HALF, 1'b0, 32'h0000_0101, 32'h0,        32'h12F0_0D34, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0110, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_F00D, 1'b0, 32'h0};
      vecs[8]  = '{1'b1, LS_BYTE, 1'b0, 32'h0000_0301, 32'h0000_00AB, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0300, 4'b0010, 32'h0000_AB00, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0, 32'h0};
      vecs[9]  = '{1'b0, LS_HALF, 1'b1, 32'h0000_01FF, 32'h0,        32'h7F00_0000, 32'h1234_5680, 1'b0, 1'b0, 1'b1, 32'h0000_01FC, 4'b1000, 32'h0,        32'h0000_0200, 4'b0001, 32'h0,        32'hFFFF_807F, 1'b0, 32'h0};
      vecs[10] = '{1'b0, LS_WORD, 1'b0, 32'h0000_0206, 32'h0,        32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b1, 32'h0000_0204, 4'b1100, 32'h0,        32'h0000_0208, 4'b0011, 32'h0,        32'h0,        1'b1, 32'h0000_0208};
      vecs[11] = '{1'b1, LS_HALF, 1'b0, 32'hFFFF_FFFF, 32'h0000_BEEF, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 32'h0000_0000, 4'b0001, 32'h0000_00BE, 32'h0,        1'b0, 32'h0};
      vecs[12] = '{1'b1, LS_WORD, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 32'h0000_0400};

      // Reset state.
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst ready", 32'(lsu_ready), 32'd1);
      chk("rst busy", 32'(lsu_busy), 32'd0);
      chk("rst req", 32'(data_req), 32'd0);
      chk("rst resp", 32'(resp), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst rdata_we", 32'(rdata_we), 32'd0);
      chk("rst addr", data_addr, 32'h0);
      chk("rst be", 32'(data_be), 32'h0);

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

      // Stray rvalid/gnt while idle produce no response.
      @(negedge clk);
      data_rvalid = 1'b1; data_gnt = 1'b1; data_rdata = 32'h5555_5555;
      #1;
      chk("stray resp", 32'(resp), 32'd0);
      @(negedge clk);
      data_rvalid = 1'b0; data_gnt = 1'b0;
      #1;
      chk("stray req", 32'(data_req), 32'd0);
      chk("stray ready", 32'(lsu_ready), 32'd1);

      // Late grant: request and address held; new request while busy ignored.
      issue(1'b0, LS_WORD, 1'b0, 32'h0000_0500, 32'h0);
      @(negedge clk);
      issue(1'b0, LS_WORD, 1'b0, 32'h0000_0600, 32'h0);
      chk("hold busy", 32'(lsu_busy), 32'd1);
      chk("hold ready", 32'(lsu_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("hold req", 32'(data_req), 32'd1);
      chk("hold addr", data_addr, 32'h0000_0500);
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0; lsu_req = 1'b0;
      data_rvalid = 1'b1; data_rdata = 32'h0BAD_CAFE;
      #1;
      chk("hold resp", 32'(resp), 32'd1);
      chk("hold rdata", rdata, 32'h0BAD_CAFE);
      @(negedge clk);
      data_rvalid = 1'b0;
      #1;
      chk("hold done req", 32'(data_req), 32'd0);

      // Reset while waiting for rvalid: back to idle, late rvalid ignored.
      issue(1'b0, LS_WORD, 1'b0, 32'h0000_0700, 32'h0);
      @(negedge clk);
      lsu_req = 1'b0; data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0;
      chk("rstmid busy", 32'(lsu_busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstmid ready", 32'(lsu_ready), 32'd1);
      chk("rstmid req", 32'(data_req), 32'd0);
      data_rvalid = 1'b1; data_rdata = 32'h1234_5678;
      #1;
      chk("rstmid resp", 32'(resp), 32'd0);
      chk("rstmid we", 32'(rdata_we), 32'd0);
      @(negedge clk);
      data_rvalid = 1'b0;

      // MisalignedEn=0 variant: no bus traffic, error pulse the cycle after accept.
      issue(1'b0, LS_WORD, 1'b0, 32'h0000_0201, 32'h0);
      @(negedge clk);
      lsu_req = 1'b0;
      #1;
      chk("nm resp", 32'(nm_resp), 32'd1);
      chk("nm err", 32'(nm_err), 32'd1);
      chk("nm err_addr", nm_err_addr, 32'h0000_0201);
      chk("nm req", 32'(nm_req), 32'd0);
      chk("nm rdata_we", 32'(nm_rdata_we), 32'd0);
      @(negedge clk);
      #1;
      chk("nm resp_once", 32'(nm_resp), 32'd0);
      chk("nm ready", 32'(nm_ready), 32'd1);
      chk("nm req_after", 32'(nm_req), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
